data_mem_ctrl: RTL

Parametrised, synchronous RV32 data memory for the MEM stage. It replaces the single-cycle combinational read/write RAM with a request/response handshake and configurable wait states. It adds byte/half/word stores through byte lanes, sign- or zero-extended sub-word loads, and misaligned/out-of-range fault reporting. It sits between the ALU_MEM and MEM_WB pipeline registers, and the MEM stage stalls while a transaction is outstanding.

---
 rtl/data_mem_ctrl_pkg.sv | 32 +++
 rtl/data_mem_ctrl_load_align.sv | 49 ++++
 rtl/data_mem_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, FSM states,
// data bus width/reset value, and the access fault rule.
package data_mem_ctrl_pkg;

  localparam int          DATA_W   = 32;
  localparam logic [31:0] DATA_RST = 32'h0000_0000;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeIll  = 2'b11;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  // Illegal size, misalignment for the size, or a word index beyond the array.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [1:0] lane,
                                        input logic       oob);
    logic f;
    case (size)
      SizeByte: f = oob;
      SizeHalf: f = oob | lane[0];
      SizeWord: f = oob | (lane != 2'b00);
      default:  f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Load data alignment: picks the addressed byte/half out of the stored word
// and sign- or zero-extends it. Word loads pass straight through.
module load_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        bsign_s;
  logic        hsign_s;

  // Select the addressed byte and half-word by lane.
  always_comb begin
    byte_s = 8'h00;
    case (lane_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
  end

  assign bsign_s = ~unsigned_i & byte_s[7];
  assign hsign_s = ~unsigned_i & half_s[15];

  // Extend the selected element to the full data width.
  always_comb begin
    data_o = DATA_RST;
    case (size_i)
      SizeByte: data_o = {{24{bsign_s}}, byte_s};
      SizeHalf: data_o = {{16{hsign_s}}, half_s};
      SizeWord: data_o = word_i;
      default:  data_o = DATA_RST;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Synchronous RV32 data memory with request/response handshake, configurable
// wait states, byte-lane stores, extended sub-word loads and fault reporting.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IdxW = $clog2(DEPTH_WORDS);
  localparam int CntW = $clog2(LATENCY + 1);
  // WAIT is left when the counter reads zero, so it is preloaded with LATENCY-2.
  localparam logic [CntW-1:0] CntLoad = CntW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic                  accept_s;
  logic [IdxW-1:0]       idx_s;
  logic [1:0]            lane_s;
  logic                  oob_s;
  logic                  err_s;
  logic [31:0]           rd_word_s;
  logic [31:0]           ld_data_s;
  logic                  wr_en_s;
  logic [3:0]            be_s;
  logic [31:0]           wd_s;

  assign accept_s  = req_valid & ready_q & (state_q == StIdle);
  assign idx_s     = addr_q[IdxW+1:2];
  assign lane_s    = addr_q[1:0];
  assign oob_s     = |addr_q[ADDR_WIDTH-1:IdxW+2];
  assign err_s     = access_fault(size_q, lane_s, oob_s);
  assign rd_word_s = mem_q[idx_s];
  assign wr_en_s   = (state_q == StExec) & we_q & ~err_s;

  load_align u_load_align (
    .word_i     (rd_word_s),
    .lane_i     (lane_s),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data_s)
  );

  // Byte enables and lane-replicated store data for the latched request.
  always_comb begin
    be_s = 4'b0000;
    wd_s = 32'h0000_0000;
    case (size_q)
      SizeByte: begin
        be_s = 4'b0001 << lane_s;
        wd_s = {4{wdata_q[7:0]}};
      end
      SizeHalf: begin
        be_s = lane_s[1] ? 4'b1100 : 4'b0011;
        wd_s = {2{wdata_q[15:0]}};
      end
      SizeWord: begin
        be_s = 4'b1111;
        wd_s = wdata_q;
      end
      default: begin
        be_s = 4'b0000;
        wd_s = 32'h0000_0000;
      end
    endcase
  end

  // FSM next state, registered handshake flags and response payload.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      StIdle: begin
        if (accept_s) begin
          ready_d = 1'b0;
          cnt_d   = CntLoad;
          state_d = (LATENCY > 1) ? StWait : StExec;
        end else begin
          ready_d = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == {CntW{1'b0}}) begin
          state_d = StExec;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StExec: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        err_d       = err_s;
        rdata_d     = (err_s | we_q) ? DATA_RST : ld_data_s;
      end
      StResp: begin
        // Ready returns with IDLE, so no accept overlaps the handshake cycle.
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rdata_d     = DATA_RST;
          err_d       = 1'b0;
          ready_d     = 1'b1;
        end else begin
          state_d = StResp;
        end
      end
      default: begin
        state_d     = StIdle;
        cnt_d       = {CntW{1'b0}};
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rdata_d     = DATA_RST;
        err_d       = 1'b0;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= {CntW{1'b0}};
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= DATA_RST;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Capture request fields on accept; inputs are ignored at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SizeByte;
      uns_q   <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= 32'h0000_0000;
    end else if (accept_s) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage array: byte-lane write at the EXEC edge, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
